// File: rtl/grid_pkg.sv
// Shared board definitions for grid_ctl and draw_ships: cell encoding,
// command opcodes, board geometry and small index/counter helpers.
package grid_pkg;

  localparam int unsigned GRID_ROWS    = 12;
  localparam int unsigned GRID_COLUMNS = 12;
  localparam int unsigned GRID_CELLS   = GRID_ROWS * GRID_COLUMNS;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_SHIP  = 2'b01,
    CELL_MISS  = 2'b10,
    CELL_HIT   = 2'b11
  } grid_status_t;

  typedef enum logic [1:0] {
    OP_PLACE = 2'b00,
    OP_SHOOT = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_t;

  function automatic logic [7:0] cell_index(input logic [3:0] row,
                                            input logic [3:0] col,
                                            input logic [7:0] cols);
    return 8'({4'b0, row} * cols + {4'b0, col});
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/grid_mem.sv
// 256x2 board storage: a registered read-only draw port and a registered
// read/write port for the controller, both read-before-write.
module grid_mem
  import grid_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] draw_addr,
  input  logic       draw_blank,
  output logic [1:0] draw_data,
  input  logic [7:0] fsm_addr,
  input  logic       fsm_we,
  input  logic [1:0] fsm_wdata,
  output logic [1:0] fsm_rdata
);

  logic [1:0] mem_q [256];
  logic [1:0] draw_data_q, draw_data_d;
  logic [1:0] fsm_rdata_q, fsm_rdata_d;

  always_comb begin
    draw_data_d = draw_blank ? CELL_EMPTY : mem_q[draw_addr];
    fsm_rdata_d = mem_q[fsm_addr];
  end

  // Storage is cleared by the controller's sweep, so it carries no reset.
  always_ff @(posedge clk) begin
    if (fsm_we) begin
      mem_q[fsm_addr] <= fsm_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      draw_data_q <= '0;
      fsm_rdata_q <= '0;
    end else begin
      draw_data_q <= draw_data_d;
      fsm_rdata_q <= fsm_rdata_d;
    end
  end

  assign draw_data = draw_data_q;
  assign fsm_rdata = fsm_rdata_q;

endmodule

// File: rtl/grid_ctl.sv
// One player's board: serves the draw read port and executes PLACE/SHOOT/CLEAR
// commands, reporting per-command results and ship/hit counters.
module grid_ctl #(
  parameter int unsigned GRID_ROWS    = grid_pkg::GRID_ROWS,
  parameter int unsigned GRID_COLUMNS = grid_pkg::GRID_COLUMNS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] grid_addr,
  output logic [1:0] grid_status,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_row,
  input  logic [3:0] cmd_col,
  output logic       rsp_valid,
  output logic [1:0] rsp_status,
  output logic       rsp_err,
  output logic [7:0] ship_cnt,
  output logic [7:0] hit_cnt,
  output logic       all_sunk
);

  import grid_pkg::*;

  localparam int unsigned CELLS     = GRID_ROWS * GRID_COLUMNS;
  localparam logic [7:0]  LAST_CELL = 8'(CELLS - 1);
  localparam logic [7:0]  COLS8     = 8'(GRID_COLUMNS);

  localparam logic [2:0] S_CLR  = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [7:0] clr_addr_q, clr_addr_d;
  logic       clr_rsp_q, clr_rsp_d;
  logic [7:0] ship_q, ship_d;
  logic [7:0] hit_q, hit_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [1:0] rsp_status_q, rsp_status_d;
  logic       rsp_err_q, rsp_err_d;

  logic [7:0] cell_addr;
  logic       out_of_range;
  logic       draw_blank;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;

  assign cell_addr    = cell_index(row_q, col_q, COLS8);
  assign out_of_range = ({5'b0, row_q} >= 9'(GRID_ROWS)) ||
                        ({5'b0, col_q} >= 9'(GRID_COLUMNS));
  assign draw_blank   = (state_q == S_CLR) || ({1'b0, grid_addr} >= 9'(CELLS));

  grid_mem u_mem (
    .clk        (clk),
    .rst        (rst),
    .draw_addr  (grid_addr),
    .draw_blank (draw_blank),
    .draw_data  (grid_status),
    .fsm_addr   (mem_addr),
    .fsm_we     (mem_we),
    .fsm_wdata  (mem_wdata),
    .fsm_rdata  (mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    row_d        = row_q;
    col_d        = col_q;
    clr_addr_d   = clr_addr_q;
    clr_rsp_d    = clr_rsp_q;
    ship_d       = ship_q;
    hit_d        = hit_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_err_d    = rsp_err_q;
    mem_we       = 1'b0;
    mem_addr     = cell_addr;
    mem_wdata    = CELL_EMPTY;

    case (state_q)
      S_CLR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr_q;
        mem_wdata = CELL_EMPTY;
        ship_d    = '0;
        hit_d     = '0;
        if (clr_addr_q == LAST_CELL) begin
          clr_addr_d = '0;
          clr_rsp_d  = 1'b0;
          if (clr_rsp_q) begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = CELL_EMPTY;
            rsp_err_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clr_addr_d = clr_addr_q + 8'd1;
        end
      end

      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          row_d = cmd_row;
          col_d = cmd_col;
          case (cmd_op)
            OP_CLEAR: begin
              state_d    = S_CLR;
              clr_addr_d = '0;
              clr_rsp_d  = 1'b1;
            end
            OP_RSVD: begin
              state_d      = S_RESP;
              rsp_valid_d  = 1'b1;
              rsp_status_d = CELL_EMPTY;
              rsp_err_d    = 1'b1;
            end
            default: state_d = S_RD;
          endcase
        end
      end

      S_RD: begin
        if (out_of_range) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = CELL_EMPTY;
          rsp_err_d    = 1'b1;
        end else begin
          state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        // Rejected commands report the cell's unchanged value.
        state_d      = S_RESP;
        rsp_valid_d  = 1'b1;
        rsp_status_d = mem_rdata;
        rsp_err_d    = 1'b1;
        if (op_q == OP_PLACE && mem_rdata == CELL_EMPTY) begin
          mem_we       = 1'b1;
          mem_wdata    = CELL_SHIP;
          ship_d       = sat_inc(ship_q);
          rsp_status_d = CELL_SHIP;
          rsp_err_d    = 1'b0;
        end else if (op_q == OP_SHOOT && mem_rdata == CELL_SHIP) begin
          mem_we       = 1'b1;
          mem_wdata    = CELL_HIT;
          hit_d        = sat_inc(hit_q);
          rsp_status_d = CELL_HIT;
          rsp_err_d    = 1'b0;
        end else if (op_q == OP_SHOOT && mem_rdata == CELL_EMPTY) begin
          mem_we       = 1'b1;
          mem_wdata    = CELL_MISS;
          rsp_status_d = CELL_MISS;
          rsp_err_d    = 1'b0;
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_CLR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CLR;
      op_q         <= '0;
      row_q        <= '0;
      col_q        <= '0;
      clr_addr_q   <= '0;
      clr_rsp_q    <= 1'b0;
      ship_q       <= '0;
      hit_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      row_q        <= row_d;
      col_q        <= col_d;
      clr_addr_q   <= clr_addr_d;
      clr_rsp_q    <= clr_rsp_d;
      ship_q       <= ship_d;
      hit_q        <= hit_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_err    = rsp_err_q;
  assign ship_cnt   = ship_q;
  assign hit_cnt    = hit_q;
  assign all_sunk   = (ship_q != 8'd0) && (hit_q == ship_q);

endmodule

// File: tb/tb_grid_ctl.sv
// Directed self-checking bench for grid_ctl: command vector table plus
// hand-written sequences for clear sweep, draw/write collision and reset.
module tb_grid_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] grid_addr;
  logic [1:0] grid_status;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_row;
  logic [3:0] cmd_col;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic       rsp_err;
  logic [7:0] ship_cnt;
  logic [7:0] hit_cnt;
  logic       all_sunk;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  grid_ctl #(.GRID_ROWS(12), .GRID_COLUMNS(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .grid_addr   (grid_addr),
    .grid_status (grid_status),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_row     (cmd_row),
    .cmd_col     (cmd_col),
    .rsp_valid   (rsp_valid),
    .rsp_status  (rsp_status),
    .rsp_err     (rsp_err),
    .ship_cnt    (ship_cnt),
    .hit_cnt     (hit_cnt),
    .all_sunk    (all_sunk)
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] row;
    logic [3:0] col;
    logic [1:0] st;
    logic       err;
    int         lat;
    logic [7:0] ship;
    logic [7:0] hit;
    logic       sunk;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Call at a negedge with rst just released; counts edges until cmd_ready.
  task automatic wait_clr(input string tag);
    int n = 0;
    logic saw = 1'b0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
      if (rsp_valid) saw = 1'b1;
    end
    chk({tag, " clr cycles"}, 32'(n), 144);
    chk({tag, " no rsp during clr"}, 32'(saw), 0);
  endtask

  task automatic read_cell(input logic [7:0] a, output logic [1:0] v);
    grid_addr = a;
    @(negedge clk);
    v = grid_status;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] row, input logic [3:0] col,
                      output int lat, output logic [1:0] st, output logic err,
                      output logic [1:0] gs0, output logic [1:0] gs1);
    int w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready before send", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = row;
    cmd_col   = col;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    st  = rsp_status;
    err = rsp_err;
    gs0 = grid_status;
    @(negedge clk);
    chk("rsp pulse width", 32'(rsp_valid), 0);
    gs1 = grid_status;
  endtask

  initial begin
    int         lat;
    int         bad;
    int         n;
    logic       rdy_seen;
    logic [1:0] st, gs0, gs1, v;
    logic       err;

    //           op    row   col   st     err  lat ship  hit  sunk
    vecs[0]  = '{2'd0, 4'd3, 4'd4, 2'b01, 1'b0, 2, 8'd1, 8'd0, 1'b0};
    vecs[1]  = '{2'd0, 4'd3, 4'd4, 2'b01, 1'b1, 2, 8'd1, 8'd0, 1'b0};
    vecs[2]  = '{2'd1, 4'd3, 4'd4, 2'b11, 1'b0, 2, 8'd1, 8'd1, 1'b1};
    vecs[3]  = '{2'd1, 4'd0, 4'd0, 2'b10, 1'b0, 2, 8'd1, 8'd1, 1'b1};
    vecs[4]  = '{2'd1, 4'd0, 4'd0, 2'b10, 1'b1, 2, 8'd1, 8'd1, 1'b1};
    vecs[5]  = '{2'd0, 4'd12, 4'd0, 2'b00, 1'b1, 1, 8'd1, 8'd1, 1'b1};
    vecs[6]  = '{2'd1, 4'd0, 4'd15, 2'b00, 1'b1, 1, 8'd1, 8'd1, 1'b1};
    vecs[7]  = '{2'd3, 4'd0, 4'd0, 2'b00, 1'b1, 0, 8'd1, 8'd1, 1'b1};
    vecs[8]  = '{2'd0, 4'd0, 4'd0, 2'b10, 1'b1, 2, 8'd1, 8'd1, 1'b1};
    vecs[9]  = '{2'd0, 4'd11, 4'd11, 2'b01, 1'b0, 2, 8'd2, 8'd1, 1'b0};
    vecs[10] = '{2'd1, 4'd11, 4'd11, 2'b11, 1'b0, 2, 8'd2, 8'd2, 1'b1};

    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_row   = '0;
    cmd_col   = '0;
    grid_addr = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset grid_status", 32'(grid_status), 0);
    chk("reset cmd_ready", 32'(cmd_ready), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_status", 32'(rsp_status), 0);
    chk("reset rsp_err", 32'(rsp_err), 0);
    chk("reset ship_cnt", 32'(ship_cnt), 0);
    chk("reset hit_cnt", 32'(hit_cnt), 0);
    chk("reset all_sunk", 32'(all_sunk), 0);
    rst = 1'b0;
    wait_clr("boot");
    chk("boot ship_cnt", 32'(ship_cnt), 0);
    chk("boot all_sunk", 32'(all_sunk), 0);

    bad = 0;
    for (int a = 0; a < 144; a++) begin
      read_cell(8'(a), v);
      if (v !== 2'b00) bad++;
    end
    chk("boot draw sweep nonzero cells", 32'(bad), 0);
    read_cell(8'd200, v);
    chk("draw addr 200", 32'(v), 0);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].op, vecs[i].row, vecs[i].col, lat, st, err, gs0, gs1);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d rsp_status", i), 32'(st), 32'(vecs[i].st));
      chk($sformatf("v%0d rsp_err", i), 32'(err), 32'(vecs[i].err));
      chk($sformatf("v%0d ship_cnt", i), 32'(ship_cnt), 32'(vecs[i].ship));
      chk($sformatf("v%0d hit_cnt", i), 32'(hit_cnt), 32'(vecs[i].hit));
      chk($sformatf("v%0d all_sunk", i), 32'(all_sunk), 32'(vecs[i].sunk));
      if (vecs[i].op != 2'd3 && vecs[i].row < 12 && vecs[i].col < 12) begin
        read_cell(8'(vecs[i].row * 12 + vecs[i].col), v);
        chk($sformatf("v%0d draw cell", i), 32'(v), 32'(vecs[i].st));
      end
    end

    // Draw port held on (5,6)=66 while a SHOOT writes it.
    send(2'd0, 4'd5, 4'd6, lat, st, err, gs0, gs1);
    chk("place 5,6 status", 32'(st), 32'b01);
    chk("place 5,6 ship_cnt", 32'(ship_cnt), 3);
    grid_addr = 8'd66;
    send(2'd1, 4'd5, 4'd6, lat, st, err, gs0, gs1);
    chk("collision old value in write cycle", 32'(gs0), 32'b01);
    chk("collision new value next cycle", 32'(gs1), 32'b11);
    chk("collision shoot status", 32'(st), 32'b11);
    chk("collision all_sunk", 32'(all_sunk), 1);

    // CLEAR: draw blanks immediately, ready stays low through the sweep.
    grid_addr = 8'd40;
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_row   = 4'd0;
    cmd_col   = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("clear ready drop", 32'(cmd_ready), 0);
    @(negedge clk);
    chk("draw blank during clr", 32'(grid_status), 0);
    n = 1;
    rdy_seen = 1'b0;
    while (!rsp_valid && n < 400) begin
      if (cmd_ready) rdy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("clear latency", 32'(n), 144);
    chk("clear ready during sweep", 32'(rdy_seen), 0);
    chk("clear rsp_status", 32'(rsp_status), 0);
    chk("clear rsp_err", 32'(rsp_err), 0);
    chk("clear ship_cnt", 32'(ship_cnt), 0);
    chk("clear hit_cnt", 32'(hit_cnt), 0);
    chk("clear all_sunk", 32'(all_sunk), 0);
    @(negedge clk);
    chk("clear rsp pulse width", 32'(rsp_valid), 0);
    chk("clear ready back", 32'(cmd_ready), 1);
    read_cell(8'd40, v);
    chk("clear cell 40", 32'(v), 0);

    // Reset while a PLACE sits in EVAL.
    send(2'd0, 4'd7, 4'd7, lat, st, err, gs0, gs1);
    chk("pre-reset place ship_cnt", 32'(ship_cnt), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_row   = 4'd2;
    cmd_col   = 4'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-eval rst rsp_valid", 32'(rsp_valid), 0);
    chk("mid-eval rst rsp_status", 32'(rsp_status), 0);
    chk("mid-eval rst ship_cnt", 32'(ship_cnt), 0);
    chk("mid-eval rst cmd_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_clr("mid-eval");
    chk("mid-eval ship_cnt after clr", 32'(ship_cnt), 0);
    read_cell(8'd26, v);
    chk("mid-eval target cell", 32'(v), 0);
    read_cell(8'd91, v);
    chk("mid-eval earlier ship cell", 32'(v), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
